// File: rtl/btb_pkg.sv
// Shared types and PC field helpers for the BTB tag/valid RAM controller.
package btb_pkg;

  localparam int INDEX_W = 10;
  localparam int TAG_W   = 22;
  localparam int DEPTH   = 2 ** INDEX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic {
    FLUSH = 1'b0,
    IDLE  = 1'b1
  } state_t;

  function automatic logic [INDEX_W-1:0] pc_index(input logic [31:0] pc);
    return pc[INDEX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return pc[31:32-TAG_W];
  endfunction

endpackage

// File: rtl/btb_tag_ctrl.sv
// Arbitrates the single BTB tag RAM port between the flush sweep, EX updates
// and the fetch lookup, and produces the fetch-stage hit.
module btb_tag_ctrl
  import btb_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush_req,
  input  logic [31:0]        i_lookup_pc,
  input  logic               i_upd_req,
  input  logic               i_upd_inv,
  input  logic [31:0]        i_upd_pc,
  output logic               o_upd_ack,
  output logic               o_ram_wren,
  output logic [INDEX_W-1:0] o_ram_addr,
  output logic [TAG_W:0]     o_ram_wdata,
  input  logic [TAG_W:0]     i_ram_rdata,
  output logic               o_lookup_valid,
  output logic               o_hit,
  output logic               o_busy,
  output logic               o_flush_done
);

  state_t             state, state_nxt;
  logic [INDEX_W-1:0] cnt, cnt_nxt;
  logic               flush_done_nxt;
  entry_t             rd_entry, wr_entry;

  assign rd_entry    = entry_t'(i_ram_rdata);
  assign o_ram_wdata = wr_entry;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= FLUSH;
      cnt          <= '0;
      o_flush_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      o_flush_done <= flush_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    flush_done_nxt = 1'b0;
    o_upd_ack      = 1'b0;
    o_ram_wren     = 1'b0;
    o_ram_addr     = pc_index(i_lookup_pc);
    wr_entry       = '0;
    o_lookup_valid = 1'b0;
    o_hit          = 1'b0;
    o_busy         = 1'b0;
    case (state)
      FLUSH: begin
        // Sweep writes an invalid entry per cycle; flush requests are absorbed.
        o_busy     = 1'b1;
        o_ram_wren = 1'b1;
        o_ram_addr = cnt;
        cnt_nxt    = cnt + 1'b1;
        if (cnt == INDEX_W'(DEPTH - 1)) begin
          state_nxt      = IDLE;
          flush_done_nxt = 1'b1;
        end
      end
      IDLE: begin
        if (i_flush_req) begin
          state_nxt = FLUSH;
          cnt_nxt   = '0;
        end else if (i_upd_req) begin
          o_ram_wren     = 1'b1;
          o_ram_addr     = pc_index(i_upd_pc);
          wr_entry.valid = ~i_upd_inv;
          wr_entry.tag   = pc_tag(i_upd_pc);
          o_upd_ack      = 1'b1;
        end else begin
          // Read data for this address is captured by the RAM on the negedge.
          o_lookup_valid = 1'b1;
          o_hit          = rd_entry.valid && (rd_entry.tag == pc_tag(i_lookup_pc));
        end
      end
      default: begin
        state_nxt = FLUSH;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
